// File: rtl/mask_gen_pkg.sv
// Shared types and frame geometry for the mask generator sequencer.
package mask_gen_pkg;

    typedef enum logic [1:0] {
        MT_SLIDE_R = 2'b00,
        MT_SLIDE_L = 2'b01,
        MT_RANDOM  = 2'b10,
        MT_REPEAT  = 2'b11
    } mask_type_e;

    typedef enum logic [2:0] {
        IDLE,
        GRST,
        LOAD,
        FETCH,
        HOLD
    } ctrl_state_e;

    localparam int VGA_ROWS = 480;
    localparam int VGA_COLS = 640;

endpackage

// File: rtl/mg_pattern_serializer.sv
// Shifts a W-bit word out LSB first, one bit per cycle, after a start pulse.
module mg_pattern_serializer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] data,
    output logic         busy,
    output logic         bit_out,
    output logic         done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    assign bit_out = sr[0];
    // done marks the cycle carrying the final bit, so the caller can leave on the same edge
    assign done    = busy && (cnt == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sr   <= data;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sr  <= sr >> 1;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mask_gen_vga_ctrl.sv
// Sequences the VGA mask generator: config latch, soft reset, serial load, then one
// generator step per active line, reporting row readiness and underruns.
module mask_gen_vga_ctrl
    import mask_gen_pkg::*;
#(
    parameter int ROWS    = VGA_ROWS,
    parameter int PAT_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_mask_type,
    input  logic [4:0]  cfg_pattern_w,
    input  logic [7:0]  cfg_repeat,
    input  logic [31:0] cfg_pattern,
    input  logic        enable,
    input  logic        line_req,
    output logic        mg_rst_n,
    output logic        mg_clk_en,
    output logic        mg_load_pattern,
    output logic        mg_pattern,
    output logic [4:0]  mg_pattern_w,
    output logic [7:0]  mg_repeat,
    output logic [1:0]  mg_mask_type,
    input  logic        mg_rp_valid,
    output logic        row_ready,
    output logic [8:0]  row_idx,
    output logic        frame_done,
    output logic        err_underrun,
    output ctrl_state_e dbg_state
);

    // Config handshake: a transfer happens on a rising edge where cfg_valid and cfg_ready are
    // both high; cfg_ready is high only in IDLE, so a held cfg_valid waits for a frame boundary.
    ctrl_state_e state;
    logic [31:0] sh_pattern;
    logic        sh_valid;
    logic        rep_load;
    logic [8:0]  row_cnt;

    logic cfg_fire, line_acc, boundary, frame_stop, is_repeat;
    logic ser_start, ser_busy, ser_bit, ser_done;

    assign cfg_fire   = cfg_valid && cfg_ready;
    assign line_acc   = line_req && (state != IDLE);
    assign boundary   = line_acc && (row_cnt == 9'(ROWS - 1));
    assign frame_stop = !enable || cfg_valid;
    assign is_repeat  = (mg_mask_type == MT_REPEAT);
    assign ser_start  = (state == GRST) && !is_repeat;

    assign mg_load_pattern = rep_load || ser_busy;
    assign mg_pattern      = ser_busy && ser_bit;
    assign dbg_state       = state;

    mg_pattern_serializer #(.W(PAT_LEN)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .start   (ser_start),
        .data    (sh_pattern[PAT_LEN-1:0]),
        .busy    (ser_busy),
        .bit_out (ser_bit),
        .done    (ser_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cfg_ready    <= 1'b1;
            mg_rst_n     <= 1'b0;
            mg_clk_en    <= 1'b0;
            rep_load     <= 1'b0;
            mg_pattern_w <= '0;
            mg_repeat    <= '0;
            mg_mask_type <= '0;
            sh_pattern   <= '0;
            sh_valid     <= 1'b0;
            row_ready    <= 1'b0;
            row_idx      <= '0;
            row_cnt      <= '0;
            frame_done   <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rep_load   <= 1'b0;

            // Rows are counted in every non-IDLE state; only HOLD has a mask ready.
            if (line_acc) begin
                row_idx    <= row_cnt;
                row_cnt    <= boundary ? 9'd0 : row_cnt + 9'd1;
                frame_done <= boundary;
                if (state != HOLD) begin
                    err_underrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        mg_mask_type <= cfg_mask_type;
                        mg_pattern_w <= cfg_pattern_w;
                        mg_repeat    <= cfg_repeat;
                        sh_pattern   <= cfg_pattern;
                        sh_valid     <= 1'b1;
                        err_underrun <= 1'b0;
                    end
                    if (enable && (sh_valid || cfg_fire)) begin
                        state     <= GRST;
                        cfg_ready <= 1'b0;
                        mg_rst_n  <= 1'b0;
                        mg_clk_en <= 1'b1;
                        row_cnt   <= '0;
                    end
                end
                GRST: begin
                    state    <= LOAD;
                    mg_rst_n <= 1'b1;
                    rep_load <= is_repeat;
                end
                LOAD: begin
                    if (is_repeat || ser_done) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (boundary && frame_stop) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        mg_rst_n  <= 1'b0;
                        mg_clk_en <= 1'b0;
                        row_ready <= 1'b0;
                    end else if (mg_rp_valid) begin
                        state     <= HOLD;
                        mg_clk_en <= 1'b0;
                        row_ready <= 1'b1;
                    end
                end
                HOLD: begin
                    if (boundary && frame_stop) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        mg_rst_n  <= 1'b0;
                        mg_clk_en <= 1'b0;
                        row_ready <= 1'b0;
                    end else if (line_req && !is_repeat) begin
                        // Repeated pattern is static: the mask stays frozen for the whole frame.
                        state     <= FETCH;
                        mg_clk_en <= 1'b1;
                        row_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rows_fit_counter: assert property (@(posedge clk) disable iff (rst) (ROWS <= 512 && PAT_LEN <= 32));

endmodule

// File: tb/tb_mask_gen_vga_ctrl.sv
// Directed bench for mask_gen_vga_ctrl: load-sequence vector table plus frame-level sequences.
module tb_mask_gen_vga_ctrl;
    import mask_gen_pkg::*;

    localparam int ROWS = 480;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_mask_type = '0;
    logic [4:0]  cfg_pattern_w = '0;
    logic [7:0]  cfg_repeat = '0;
    logic [31:0] cfg_pattern = '0;
    logic        enable = 1'b0;
    logic        line_req = 1'b0;
    logic        mg_rst_n, mg_clk_en, mg_load_pattern, mg_pattern;
    logic [4:0]  mg_pattern_w;
    logic [7:0]  mg_repeat;
    logic [1:0]  mg_mask_type;
    logic        mg_rp_valid;
    logic        row_ready;
    logic [8:0]  row_idx;
    logic        frame_done;
    logic        err_underrun;
    ctrl_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int seq_bad  = 0;

    mask_gen_vga_ctrl #(.ROWS(ROWS), .PAT_LEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_mask_type   (cfg_mask_type),
        .cfg_pattern_w   (cfg_pattern_w),
        .cfg_repeat      (cfg_repeat),
        .cfg_pattern     (cfg_pattern),
        .enable          (enable),
        .line_req        (line_req),
        .mg_rst_n        (mg_rst_n),
        .mg_clk_en       (mg_clk_en),
        .mg_load_pattern (mg_load_pattern),
        .mg_pattern      (mg_pattern),
        .mg_pattern_w    (mg_pattern_w),
        .mg_repeat       (mg_repeat),
        .mg_mask_type    (mg_mask_type),
        .mg_rp_valid     (mg_rp_valid),
        .row_ready       (row_ready),
        .row_idx         (row_idx),
        .frame_done      (frame_done),
        .err_underrun    (err_underrun),
        .dbg_state       (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // Generator stand-in: a mask row is valid after two free-running enabled clocks.
    int gen_cnt = 0;
    always @(posedge clk) begin
        if (!mg_clk_en || !mg_rst_n || mg_load_pattern) gen_cnt <= 0;
        else gen_cnt <= gen_cnt + 1;
    end
    assign mg_rp_valid = (gen_cnt >= 2);

    // Output monitor
    int          ld_idx = 0;
    int          ld_total = 0;
    logic [31:0] cap = '0;
    int          rr_rise = 0;
    logic        rr_prev = 1'b0;
    int          fd_count = 0;

    always @(negedge clk) begin
        if (rst || (mg_clk_en && !mg_rst_n)) begin
            ld_idx = 0;
            cap    = '0;
        end else if (mg_load_pattern) begin
            if (ld_idx < 32) cap[ld_idx] = mg_pattern;
            ld_idx++;
            ld_total++;
        end
        if (row_ready && !rr_prev) rr_rise++;
        rr_prev = row_ready;
        if (frame_done) fd_count++;
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        rst       = 1'b1;
        cfg_valid = 1'b0;
        line_req  = 1'b0;
        enable    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_cfg(input logic [1:0] t, input logic [4:0] w, input logic [7:0] rp,
                            input logic [31:0] pat);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        cfg_mask_type = t;
        cfg_pattern_w = w;
        cfg_repeat    = rp;
        cfg_pattern   = pat;
        cfg_valid     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (row_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, {31'd0, row_ready}, 32'd1);
    endtask

    task automatic send_line(input int exp_row, input int gap);
        @(negedge clk);
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
        if (row_idx !== 9'(exp_row) || frame_done !== (exp_row == ROWS - 1)) seq_bad++;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_rows(input int first, input int gap, input int drop_at);
        for (int r = first; r < ROWS; r++) begin
            send_line(r, gap);
            if (r == drop_at) enable = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_state"}, {29'd0, dbg_state}, {29'd0, IDLE});
        check({name, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
        check({name, "_clk_en"}, {31'd0, mg_clk_en}, 32'd0);
        check({name, "_row_ready"}, {31'd0, row_ready}, 32'd0);
    endtask

    // Load-sequence vectors: config in, expected load length and serial word out.
    typedef struct {
        logic [1:0]  mtype;
        logic [4:0]  w;
        logic [7:0]  rep;
        logic [31:0] pat;
        int          exp_loads;
        logic [31:0] exp_bits;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int fd_base, rr_base, ld_snap;

        vecs[0] = '{2'b00, 5'd16, 8'h00, 32'h03D0A052, 32, 32'h03D0A052};
        vecs[1] = '{2'b01, 5'd31, 8'h3C, 32'hFFFF0001, 32, 32'hFFFF0001};
        vecs[2] = '{2'b10, 5'd1,  8'hFF, 32'h80000000, 32, 32'h80000000};
        vecs[3] = '{2'b00, 5'd7,  8'h11, 32'hAAAA5555, 32, 32'hAAAA5555};
        vecs[4] = '{2'b11, 5'd8,  8'hA5, 32'hFFFFFFFF, 1,  32'h00000000};

        // Reset values
        do_reset();
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_mg_rst_n", {31'd0, mg_rst_n}, 32'd0);
        check("rst_clk_en", {31'd0, mg_clk_en}, 32'd0);
        check("rst_load", {31'd0, mg_load_pattern}, 32'd0);
        check("rst_pattern", {31'd0, mg_pattern}, 32'd0);
        check("rst_cfg_copy", {17'd0, mg_mask_type, mg_pattern_w, mg_repeat}, 32'd0);
        check("rst_row_ready", {31'd0, row_ready}, 32'd0);
        check("rst_row_idx", {23'd0, row_idx}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_err", {31'd0, err_underrun}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});

        // Table: one load + first fetch per vector
        for (int v = 0; v < 5; v++) begin
            do_reset();
            send_cfg(vecs[v].mtype, vecs[v].w, vecs[v].rep, vecs[v].pat);
            @(negedge clk);
            enable = 1'b1;
            wait_ready($sformatf("vec%0d", v));
            check($sformatf("vec%0d_loads", v), ld_idx, vecs[v].exp_loads);
            check($sformatf("vec%0d_bits", v), cap, vecs[v].exp_bits);
            check($sformatf("vec%0d_type", v), {30'd0, mg_mask_type}, {30'd0, vecs[v].mtype});
            check($sformatf("vec%0d_w", v), {27'd0, mg_pattern_w}, {27'd0, vecs[v].w});
            check($sformatf("vec%0d_rep", v), {24'd0, mg_repeat}, {24'd0, vecs[v].rep});
            check($sformatf("vec%0d_hold_clk_en", v), {31'd0, mg_clk_en}, 32'd0);
            check($sformatf("vec%0d_cfg_ready", v), {31'd0, cfg_ready}, 32'd0);
            check($sformatf("vec%0d_state", v), {29'd0, dbg_state}, {29'd0, HOLD});
            enable = 1'b0;
        end

        // Asynchronous reset in the middle of a serial load
        do_reset();
        send_cfg(2'b00, 5'd4, 8'h00, 32'hFFFFFFFF);
        @(negedge clk);
        enable = 1'b1;
        for (int n = 0; n < 100 && ld_idx < 10; n++) @(negedge clk);
        check("midload_reached", {31'd0, mg_load_pattern}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midload_rst_load", {31'd0, mg_load_pattern}, 32'd0);
        check("midload_rst_clk_en", {31'd0, mg_clk_en}, 32'd0);
        check("midload_rst_mg_rst_n", {31'd0, mg_rst_n}, 32'd0);
        check("midload_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        ld_snap = ld_total;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("midload_no_resume", ld_total, ld_snap);
        check("midload_idle", {29'd0, dbg_state}, {29'd0, IDLE});

        // Repeated-pattern frame: one fetch serves all rows
        do_reset();
        send_cfg(2'b11, 5'd8, 8'hA5, 32'h0);
        rr_base = rr_rise;
        fd_base = fd_count;
        @(negedge clk);
        enable = 1'b1;
        wait_ready("rep");
        seq_bad = 0;
        run_rows(0, 3, 470);
        check("rep_row_seq", seq_bad, 0);
        check("rep_frame_done", fd_count - fd_base, 1);
        check("rep_fetches", rr_rise - rr_base, 1);
        check("rep_last_row", {23'd0, row_idx}, 32'd479);
        check("rep_err", {31'd0, err_underrun}, 32'd0);
        check_idle("rep_end");

        // Random type, every row fetched, enable dropped at row 200
        send_cfg(2'b10, 5'd12, 8'h00, 32'h1234ABCD);
        rr_base = rr_rise;
        fd_base = fd_count;
        @(negedge clk);
        enable = 1'b1;
        wait_ready("rnd");
        seq_bad = 0;
        run_rows(0, 16, 200);
        check("rnd_row_seq", seq_bad, 0);
        check("rnd_frame_done", fd_count - fd_base, 1);
        check("rnd_fetches", rr_rise - rr_base, 480);
        check("rnd_err", {31'd0, err_underrun}, 32'd0);
        check_idle("rnd_end");

        // Underrun: rows arriving during GRST and during a pending fetch
        send_cfg(2'b00, 5'd3, 8'h00, 32'h0F0F0F0F);
        @(negedge clk);
        enable = 1'b1;
        send_line(0, 0);
        check("udr_grst_row", {23'd0, row_idx}, 32'd0);
        check("udr_grst_err", {31'd0, err_underrun}, 32'd1);
        wait_ready("udr");
        send_line(1, 0);
        send_line(2, 0);
        check("udr_fetch_row", {23'd0, row_idx}, 32'd2);
        check("udr_fetch_err", {31'd0, err_underrun}, 32'd1);
        seq_bad = 0;
        run_rows(3, 8, 300);
        check("udr_row_seq", seq_bad, 0);
        check("udr_sticky", {31'd0, err_underrun}, 32'd1);
        check_idle("udr_end");
        send_cfg(2'b01, 5'd2, 8'h00, 32'h1);
        check("udr_cleared", {31'd0, err_underrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
